// File: rtl/rv_inst_encoder_loader.sv
// RV32I field-to-word encoder that streams encoded instructions into IROM at consecutive word addresses.
// Optional macro RV_ENC_IMM_CHECK_EN: flag and drop beats whose immediate does not fit its field.
module rv_inst_encoder_loader #(
    parameter int ADDR_W = 14
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [4:0]        in_kind,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [31:0]       in_imm,
    input  logic              in_last,
    output logic              irom_we,
    output logic [ADDR_W-1:0] irom_addr,
    output logic [31:0]       irom_wdata,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W-1:0] count
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [ADDR_W-1:0] ADDR_MAX  = {ADDR_W{1'b1}};
    localparam logic [ADDR_W-1:0] ADDR_ZERO = {ADDR_W{1'b0}};
    localparam logic [ADDR_W-1:0] ADDR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};

    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_JALR = 7'b1100111;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_B    = 7'b1100011;
    localparam logic [6:0] OP_LUI  = 7'b0110111;
    localparam logic [6:0] OP_JAL  = 7'b1101111;

    function automatic logic [31:0] enc_word(
        input logic [4:0]  kind,
        input logic [4:0]  rd,
        input logic [4:0]  rs1,
        input logic [4:0]  rs2,
        input logic [31:0] imm
    );
        logic [31:0] w;
        w = 32'h0000_0000;
        case (kind)
            5'd0:  w = {7'b0000000, rs2, rs1, 3'b000, rd, OP_R};
            5'd1:  w = {7'b0100000, rs2, rs1, 3'b000, rd, OP_R};
            5'd2:  w = {7'b0000000, rs2, rs1, 3'b111, rd, OP_R};
            5'd3:  w = {7'b0000000, rs2, rs1, 3'b110, rd, OP_R};
            5'd4:  w = {7'b0000000, rs2, rs1, 3'b100, rd, OP_R};
            5'd5:  w = {7'b0000000, rs2, rs1, 3'b001, rd, OP_R};
            5'd6:  w = {7'b0000000, rs2, rs1, 3'b101, rd, OP_R};
            5'd7:  w = {7'b0100000, rs2, rs1, 3'b101, rd, OP_R};
            5'd8:  w = {imm[11:0], rs1, 3'b000, rd, OP_I};
            5'd9:  w = {imm[11:0], rs1, 3'b111, rd, OP_I};
            5'd10: w = {imm[11:0], rs1, 3'b110, rd, OP_I};
            5'd11: w = {imm[11:0], rs1, 3'b100, rd, OP_I};
            5'd12: w = {7'b0000000, imm[4:0], rs1, 3'b001, rd, OP_I};
            5'd13: w = {7'b0000000, imm[4:0], rs1, 3'b101, rd, OP_I};
            5'd14: w = {7'b0100000, imm[4:0], rs1, 3'b101, rd, OP_I};
            5'd15: w = {imm[11:0], rs1, 3'b010, rd, OP_LW};
            5'd16: w = {imm[11:0], rs1, 3'b000, rd, OP_JALR};
            5'd17: w = {imm[11:5], rs2, rs1, 3'b010, imm[4:0], OP_SW};
            5'd18: w = {imm[12], imm[10:5], rs2, rs1, 3'b000, imm[4:1], imm[11], OP_B};
            5'd19: w = {imm[12], imm[10:5], rs2, rs1, 3'b001, imm[4:1], imm[11], OP_B};
            5'd20: w = {imm[12], imm[10:5], rs2, rs1, 3'b100, imm[4:1], imm[11], OP_B};
            5'd21: w = {imm[12], imm[10:5], rs2, rs1, 3'b101, imm[4:1], imm[11], OP_B};
            5'd22: w = {imm[31:12], rd, OP_LUI};
            5'd23: w = {imm[20], imm[10:1], imm[11], imm[19:12], rd, OP_JAL};
            default: w = 32'h0000_0000;
        endcase
        return w;
    endfunction

`ifdef RV_ENC_IMM_CHECK_EN
    function automatic logic imm_out_of_range(input logic [4:0] kind, input logic [31:0] imm);
        logic bad;
        bad = 1'b0;
        case (kind)
            5'd8, 5'd9, 5'd10, 5'd11, 5'd15, 5'd16, 5'd17:
                bad = (imm[31:11] != {21{imm[11]}});
            5'd12, 5'd13, 5'd14:
                bad = (imm[31:5] != 27'd0);
            5'd18, 5'd19, 5'd20, 5'd21:
                bad = (imm[31:12] != {20{imm[12]}}) || imm[0];
            5'd22:
                bad = (imm[11:0] != 12'd0);
            5'd23:
                bad = (imm[31:20] != {12{imm[20]}}) || imm[0];
            default:
                bad = 1'b0;
        endcase
        return bad;
    endfunction
`endif

    state_t            state_r;
    state_t            state_nxt_s;
    logic [ADDR_W-1:0] ptr_r;
    logic [ADDR_W-1:0] count_r;
    logic [ADDR_W-1:0] addr_r;
    logic [31:0]       wdata_r;
    logic              we_r;
    logic              ready_r;
    logic              busy_r;
    logic              done_r;
    logic              err_r;
    logic              accept_s;
    logic              legal_s;
    logic              imm_bad_s;
    logic              wr_s;
    logic [31:0]       word_s;

`ifdef RV_ENC_IMM_CHECK_EN
    assign imm_bad_s = imm_out_of_range(in_kind, in_imm);
`else
    assign imm_bad_s = 1'b0;
`endif

    // Beat acceptance, legality and encoded word
    always_comb begin
        accept_s = in_valid & ready_r & ~start;
        legal_s  = (in_kind < 5'd24);
        wr_s     = accept_s & legal_s & ~imm_bad_s;
        word_s   = enc_word(in_kind, in_rd, in_rs1, in_rs2, in_imm);
    end

    // Next-state logic; start restarts from any state
    always_comb begin
        state_nxt_s = state_r;
        if (start) begin
            state_nxt_s = ST_RUN;
        end else begin
            case (state_r)
                ST_IDLE:  state_nxt_s = ST_IDLE;
                ST_RUN: begin
                    if (accept_s && in_last) begin
                        state_nxt_s = ST_FLUSH;
                    end else begin
                        state_nxt_s = ST_RUN;
                    end
                end
                ST_FLUSH: state_nxt_s = ST_DONE;
                ST_DONE:  state_nxt_s = ST_IDLE;
                default:  state_nxt_s = ST_IDLE;
            endcase
        end
    end

    // State register and registered status outputs derived from the next state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            ready_r <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            ready_r <= (state_nxt_s == ST_RUN);
            busy_r  <= (state_nxt_s != ST_IDLE);
            done_r  <= (state_nxt_s == ST_DONE);
        end
    end

    // Write port, address pointer, word count and sticky error
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_r    <= 1'b0;
            addr_r  <= ADDR_ZERO;
            wdata_r <= 32'h0000_0000;
            ptr_r   <= ADDR_ZERO;
            count_r <= ADDR_ZERO;
            err_r   <= 1'b0;
        end else begin
            we_r <= wr_s;
            if (wr_s) begin
                addr_r  <= ptr_r;
                wdata_r <= word_s;
            end
            if (start) begin
                ptr_r   <= base_addr;
                count_r <= ADDR_ZERO;
                err_r   <= 1'b0;
            end else begin
                if (wr_s) begin
                    ptr_r <= ptr_r + ADDR_ONE;
                    if (count_r != ADDR_MAX) begin
                        count_r <= count_r + ADDR_ONE;
                    end
                end
                // Illegal or out-of-range beats, and a write at the top address, latch err
                if ((accept_s && (!legal_s || imm_bad_s)) || (wr_s && (ptr_r == ADDR_MAX))) begin
                    err_r <= 1'b1;
                end
            end
        end
    end

    assign in_ready   = ready_r;
    assign irom_we    = we_r;
    assign irom_addr  = addr_r;
    assign irom_wdata = wdata_r;
    assign busy       = busy_r;
    assign done       = done_r;
    assign err        = err_r;
    assign count      = count_r;

endmodule

// File: tb/tb_rv_inst_encoder_loader.sv
// Self-checking bench for rv_inst_encoder_loader: directed programs plus random beats against an arithmetic encoder model.
module tb_rv_inst_encoder_loader;

    localparam int ADDR_W = 14;
    localparam int DEPTH  = 1 << ADDR_W;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic [ADDR_W-1:0] base_addr = '0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [4:0]        in_kind = '0;
    logic [4:0]        in_rd = '0;
    logic [4:0]        in_rs1 = '0;
    logic [4:0]        in_rs2 = '0;
    logic [31:0]       in_imm = '0;
    logic              in_last = 1'b0;
    logic              irom_we;
    logic [ADDR_W-1:0] irom_addr;
    logic [31:0]       irom_wdata;
    logic              busy;
    logic              done;
    logic              err;
    logic [ADDR_W-1:0] count;

    rv_inst_encoder_loader #(.ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
        .in_valid(in_valid), .in_ready(in_ready), .in_kind(in_kind), .in_rd(in_rd),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm), .in_last(in_last),
        .irom_we(irom_we), .irom_addr(irom_addr), .irom_wdata(irom_wdata),
        .busy(busy), .done(done), .err(err), .count(count)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int done_total = 0;
    int obs_addr_q[$];
    logic [31:0] obs_data_q[$];
    int obs_cyc_q[$];
    int obs_rd = 0;
    int exp_addr_q[$];
    logic [31:0] exp_data_q[$];

    int m_ptr = 0;
    int m_count = 0;
    bit m_err = 1'b0;
    int done_base = 0;

    int r_f3 [0:7] = '{0, 0, 7, 6, 4, 1, 5, 5};
    int i_f3 [0:6] = '{0, 7, 6, 4, 1, 5, 5};
    int b_f3 [0:3] = '{0, 1, 4, 5};

    // Cycle counter for latency/bubble checks
    always @(posedge clk) cyc <= cyc + 1;

    // Write and done monitor, sampled away from the active edge
    always @(negedge clk) begin
        if (irom_we === 1'b1) begin
            obs_addr_q.push_back(int'(irom_addr));
            obs_data_q.push_back(irom_wdata);
            obs_cyc_q.push_back(cyc);
        end
        if (done === 1'b1) done_total <= done_total + 1;
    end

    function automatic logic [31:0] ref_word(input int kind, input int rd, input int rs1,
                                             input int rs2, input logic [31:0] imm);
        logic [31:0] d, s1, s2, w, imm12;
        d  = 32'(rd) << 7;
        s1 = 32'(rs1) << 15;
        s2 = 32'(rs2) << 20;
        w  = 32'h0;
        if (kind <= 7) begin
            w = 32'h33 | d | s1 | s2 | (32'(r_f3[kind]) << 12)
                | (((kind == 1) || (kind == 7)) ? 32'h4000_0000 : 32'h0);
        end else if (kind <= 14) begin
            if (kind >= 12) imm12 = (imm & 32'h1F) | ((kind == 14) ? 32'h400 : 32'h0);
            else            imm12 = imm & 32'hFFF;
            w = 32'h13 | d | s1 | (32'(i_f3[kind-8]) << 12) | (imm12 << 20);
        end else if (kind == 15) begin
            w = 32'h03 | d | s1 | 32'h2000 | ((imm & 32'hFFF) << 20);
        end else if (kind == 16) begin
            w = 32'h67 | d | s1 | ((imm & 32'hFFF) << 20);
        end else if (kind == 17) begin
            w = 32'h23 | s1 | s2 | 32'h2000 | ((imm & 32'h1F) << 7) | (((imm >> 5) & 32'h7F) << 25);
        end else if (kind <= 21) begin
            w = 32'h63 | s1 | s2 | (32'(b_f3[kind-18]) << 12)
                | (((imm >> 1) & 32'hF) << 8) | (((imm >> 11) & 32'h1) << 7)
                | (((imm >> 5) & 32'h3F) << 25) | (((imm >> 12) & 32'h1) << 31);
        end else if (kind == 22) begin
            w = 32'h37 | d | (imm & 32'hFFFF_F000);
        end else begin
            w = 32'h6F | d | (((imm >> 12) & 32'hFF) << 12) | (((imm >> 11) & 32'h1) << 20)
                | (((imm >> 1) & 32'h3FF) << 21) | (((imm >> 20) & 32'h1) << 31);
        end
        return w;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_start(input int base);
        start = 1'b1;
        base_addr = ADDR_W'(base);
        tick(1);
        start = 1'b0;
        m_ptr = base;
        m_count = 0;
        m_err = 1'b0;
        done_base = done_total;
    endtask

    task automatic send(input int kind, input int rd, input int rs1, input int rs2,
                        input logic [31:0] imm, input logic last);
        int waited = 0;
        in_valid = 1'b1;
        in_kind = 5'(kind); in_rd = 5'(rd); in_rs1 = 5'(rs1); in_rs2 = 5'(rs2);
        in_imm = imm; in_last = last;
        while (in_ready !== 1'b1 && waited < 20) begin
            tick(1);
            waited++;
        end
        check("ready_wait", 64'(waited < 20), 64'd1);
        tick(1);
        in_valid = 1'b0;
        in_last = 1'b0;
        if (kind < 24) begin
            exp_addr_q.push_back(m_ptr);
            exp_data_q.push_back(ref_word(kind, rd, rs1, rs2, imm));
            if (m_ptr == DEPTH - 1) m_err = 1'b1;
            m_ptr = (m_ptr + 1) % DEPTH;
            if (m_count < DEPTH - 1) m_count++;
        end else begin
            m_err = 1'b1;
        end
    endtask

    task automatic drain(input string tag);
        check({tag, "_nwrites"}, 64'(obs_addr_q.size() - obs_rd), 64'(exp_addr_q.size()));
        while (exp_addr_q.size() > 0 && obs_rd < obs_addr_q.size()) begin
            check({tag, "_addr"}, 64'(obs_addr_q[obs_rd]), 64'(exp_addr_q.pop_front()));
            check({tag, "_wdata"}, 64'(obs_data_q[obs_rd]), 64'(exp_data_q.pop_front()));
            obs_rd++;
        end
        exp_addr_q.delete();
        exp_data_q.delete();
        obs_rd = obs_addr_q.size();
    endtask

    task automatic wait_done(input string tag);
        int waited = 0;
        while (done !== 1'b1 && waited < 10) begin
            tick(1);
            waited++;
        end
        check({tag, "_done"}, 64'(done), 64'd1);
        check({tag, "_busy_at_done"}, 64'(busy), 64'd1);
        tick(1);
        check({tag, "_done_low"}, 64'(done), 64'd0);
        check({tag, "_busy_low"}, 64'(busy), 64'd0);
        check({tag, "_ready_low"}, 64'(in_ready), 64'd0);
        check({tag, "_done_pulses"}, 64'(done_total - done_base), 64'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready"}, 64'(in_ready), 64'd0);
        check({tag, "_irom_we"}, 64'(irom_we), 64'd0);
        check({tag, "_done"}, 64'(done), 64'd0);
        check({tag, "_err"}, 64'(err), 64'd0);
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check({tag, "_irom_addr"}, 64'(irom_addr), 64'd0);
        check({tag, "_irom_wdata"}, 64'(irom_wdata), 64'd0);
        check({tag, "_count"}, 64'(count), 64'd0);
    endtask

    initial begin
        tick(3);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        tick(1);

        // Single addi with live latency check
        do_start(0);
        check("start_busy", 64'(busy), 64'd1);
        check("start_ready", 64'(in_ready), 64'd1);
        send(8, 1, 0, 0, 32'd5, 1'b0);
        check("addi_we", 64'(irom_we), 64'd1);
        check("addi_addr", 64'(irom_addr), 64'd0);
        check("addi_wdata", 64'(irom_wdata), 64'h0050_0093);
        check("addi_count", 64'(count), 64'd1);
        tick(1);
        drain("addi");

        // add/sub back-to-back, then the directed word table
        do_start(0);
        send(0, 3, 1, 2, 32'd0, 1'b0);
        send(1, 3, 1, 2, 32'd0, 1'b0);
        tick(1);
        check("nobubble", 64'(obs_cyc_q[obs_rd+1] - obs_cyc_q[obs_rd]), 64'd1);
        check("add_const", 64'(obs_data_q[obs_rd]), 64'h0020_81B3);
        check("sub_const", 64'(obs_data_q[obs_rd+1]), 64'h4020_81B3);
        drain("addsub");
        send(14, 4, 1, 0, 32'd3, 1'b0);
        send(22, 5, 0, 0, 32'h1234_5000, 1'b0);
        send(17, 0, 1, 2, 32'd4, 1'b0);
        send(18, 0, 1, 2, 32'd8, 1'b0);
        send(23, 1, 0, 0, 32'd16, 1'b1);
        tick(1);
        check("srai_const", 64'(obs_data_q[obs_rd]), 64'h4030_D213);
        check("lui_const", 64'(obs_data_q[obs_rd+1]), 64'h1234_52B7);
        check("sw_const", 64'(obs_data_q[obs_rd+2]), 64'h0020_A223);
        check("beq_const", 64'(obs_data_q[obs_rd+3]), 64'h0020_8463);
        check("jal_const", 64'(obs_data_q[obs_rd+4]), 64'h0100_00EF);
        wait_done("prog1");
        drain("prog1");
        check("prog1_count", 64'(count), 64'd7);
        check("prog1_err", 64'(err), 64'd0);

        // Illegal kind mid-stream: no write, err set, address unchanged
        do_start(32'h100);
        send(8, 2, 0, 0, 32'd7, 1'b0);
        send(27, 1, 1, 1, 32'd1, 1'b0);
        check("illegal_err", 64'(err), 64'd1);
        send(9, 3, 2, 0, 32'h0000_0FF0, 1'b1);
        wait_done("illegal");
        drain("illegal");
        check("illegal_count", 64'(count), 64'd2);

        // Address wrap at the top of IROM
        do_start(DEPTH - 1);
        send(8, 1, 0, 0, 32'd1, 1'b0);
        check("wrap_err_first", 64'(err), 64'd1);
        send(8, 2, 0, 0, 32'd2, 1'b1);
        wait_done("wrap");
        drain("wrap");
        check("wrap_count", 64'(count), 64'd2);
        check("wrap_err", 64'(err), 64'd1);

        // start beats same-cycle in_valid; a registered write still issues after restart
        do_start(32'h20);
        in_valid = 1'b1; in_kind = 5'd8; in_rd = 5'd1; in_imm = 32'd9;
        start = 1'b1; base_addr = ADDR_W'(32'h40);
        tick(1);
        start = 1'b0; in_valid = 1'b0;
        m_ptr = 32'h40; m_count = 0; m_err = 1'b0; done_base = done_total;
        tick(1);
        check("prio_count", 64'(count), 64'd0);
        drain("prio");
        send(8, 6, 0, 0, 32'd11, 1'b0);
        do_start(32'h80);
        send(10, 7, 3, 0, 32'd12, 1'b1);
        wait_done("restart");
        drain("restart");

        // Randomized programs against the model
        for (int p = 0; p < 3; p++) begin
            do_start(DEPTH - 1 - $urandom_range(0, 40));
            for (int b = 0; b < 30; b++) begin
                logic [31:0] imm;
                imm = ($urandom_range(0, 1) == 0) ? $urandom : ($urandom & 32'h0000_1FFF);
                send($urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31),
                     $urandom_range(0, 31), imm, (b == 29));
                if (b != 29 && $urandom_range(0, 3) == 0) begin
                    in_kind = 5'($urandom_range(0, 31));
                    tick($urandom_range(1, 2));
                end
            end
            wait_done("rand");
            drain("rand");
            check("rand_count", 64'(count), 64'(m_count));
            check("rand_err", 64'(err), 64'(m_err));
        end

        // Asynchronous reset in the middle of a run
        do_start(5);
        send(8, 1, 0, 0, 32'd3, 1'b0);
        in_valid = 1'b1;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        in_valid = 1'b0;
        exp_addr_q.delete();
        exp_data_q.delete();
        tick(2);
        rst_n = 1'b1;
        tick(1);
        check("midrst_idle_busy", 64'(busy), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
